// File: rtl/riscv_kernel_ctrl_pkg.sv
// Shared encodings for the RISC-V kernel run controller.
package riscv_kernel_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] EXIT_NONE    = 2'd0;
  localparam logic [1:0] EXIT_PC      = 2'd1;
  localparam logic [1:0] EXIT_HALT    = 2'd2;
  localparam logic [1:0] EXIT_TIMEOUT = 2'd3;

endpackage

// File: rtl/riscv_kernel_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module kernel_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // Clear wins over enable; stop incrementing once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      count <= '0;
    else if (clear)                  count <= '0;
    else if (enable && count != '1)  count <= count + 1'b1;
  end

endmodule

// File: rtl/riscv_kernel_ctrl.sv
// ap_ctrl_hs run controller: hold core in reset, run until pc end / halt /
// timeout, drain the pipeline, then pulse ap_done/ap_ready.
module riscv_kernel_ctrl
  import riscv_kernel_pkg::*;
#(
  parameter int ADDR_W_IMEM  = 6,
  parameter int IMEM_SIZE    = 40,
  parameter int RST_HOLD     = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 0
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_ready,
  output logic                   ap_idle,
  input  logic [ADDR_W_IMEM:0]   prog_len,
  input  logic [31:0]            core_pc,
  input  logic                   core_halt,
  output logic                   core_rst,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [1:0]             exit_cause
);

  // One down-counter serves both HOLD and DRAIN, sized for the longer of the two.
  localparam int DMAX = (RST_HOLD > DRAIN_CYCLES) ? RST_HOLD : DRAIN_CYCLES;
  localparam int DCW  = $clog2(DMAX + 1);

  state_t               state, nxt;
  logic [DCW-1:0]       dcnt, dcnt_nxt;
  logic [ADDR_W_IMEM:0] end_idx;
  logic [ADDR_W_IMEM:0] pc_idx;
  logic                 accept, run_en, end_hit, timeout;
  logic [1:0]           cause_nxt;
  logic                 pc_unused;

  assign pc_idx    = {1'b0, core_pc[ADDR_W_IMEM+1:2]};
  assign pc_unused = ^{core_pc[31:ADDR_W_IMEM+2], core_pc[1:0]};
  assign timeout   = (MAX_CYCLES != 0) && (cycle_count == CNT_W'(MAX_CYCLES - 1));

  // Next-state, shared down-counter and end-of-program detection.
  always_comb begin
    nxt       = state;
    dcnt_nxt  = dcnt;
    accept    = 1'b0;
    run_en    = 1'b0;
    end_hit   = 1'b0;
    cause_nxt = EXIT_NONE;
    case (state)
      IDLE: begin
        if (ap_start) begin
          accept   = 1'b1;
          nxt      = HOLD;
          dcnt_nxt = DCW'(RST_HOLD - 1);
        end
      end
      HOLD: begin
        if (dcnt == '0) nxt = RUN;
        else            dcnt_nxt = dcnt - 1'b1;
      end
      RUN: begin
        run_en = 1'b1;
        // Halt outranks pc end, which outranks timeout.
        if (core_halt)              cause_nxt = EXIT_HALT;
        else if (pc_idx >= end_idx) cause_nxt = EXIT_PC;
        else if (timeout)           cause_nxt = EXIT_TIMEOUT;
        if (cause_nxt != EXIT_NONE) begin
          end_hit = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            nxt = DONE;
          end else begin
            nxt      = DRAIN;
            dcnt_nxt = DCW'(DRAIN_CYCLES - 1);
          end
        end
      end
      DRAIN: begin
        if (dcnt == '0) nxt = DONE;
        else            dcnt_nxt = dcnt - 1'b1;
      end
      DONE: begin
        // Back-to-back job: go straight to HOLD without an IDLE cycle.
        if (ap_start) begin
          accept   = 1'b1;
          nxt      = HOLD;
          dcnt_nxt = DCW'(RST_HOLD - 1);
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, job context and registered handshake outputs (decoded from next state).
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      dcnt       <= '0;
      end_idx    <= '0;
      exit_cause <= EXIT_NONE;
      core_rst   <= 1'b1;
      ap_idle    <= 1'b1;
      ap_done    <= 1'b0;
      ap_ready   <= 1'b0;
    end else begin
      state    <= nxt;
      dcnt     <= dcnt_nxt;
      core_rst <= !(nxt == RUN || nxt == DRAIN);
      ap_idle  <= (nxt == IDLE);
      ap_done  <= (nxt == DONE);
      ap_ready <= (nxt == DONE);
      if (accept) begin
        end_idx    <= (prog_len == '0) ? (ADDR_W_IMEM+1)'(IMEM_SIZE) : prog_len;
        exit_cause <= EXIT_NONE;
      end else if (end_hit) begin
        exit_cause <= cause_nxt;
      end
    end
  end

  kernel_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk    (ap_clk),
    .rst_n  (ap_rst_n),
    .clear  (accept),
    .enable (run_en),
    .count  (cycle_count)
  );

endmodule

// File: tb/tb_riscv_kernel_ctrl.sv
// Scoreboard bench: three controller instances (defaults, 16-cycle timeout,
// 4-bit counter with no drain). Stimulus pushes expected job results; a
// monitor pops and compares on every ap_done.
module tb_riscv_kernel_ctrl;

  typedef struct {
    int cc;
    int cause;
    int done_cyc;
  } exp_t;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [6:0]  prog_len = '0;
  logic        start [3];
  logic [31:0] pc    [3];
  logic        halt  [3];
  logic        done  [3];
  logic        ready [3];
  logic        idle  [3];
  logic        crst  [3];
  logic [1:0]  cause [3];
  logic [31:0] cc0, cc1;
  logic [3:0]  cc2;

  exp_t q0[$], q1[$], q2[$];
  int cyc = 0;
  int compared = 0, mismatched = 0;
  int rc[3]      = '{0, 0, 0};
  int step[3]    = '{0, 0, 0};
  int halt_at[3] = '{0, 0, 0};
  int low0 = 0;

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  riscv_kernel_ctrl u_dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start[0]), .ap_done(done[0]),
    .ap_ready(ready[0]), .ap_idle(idle[0]), .prog_len(prog_len), .core_pc(pc[0]),
    .core_halt(halt[0]), .core_rst(crst[0]), .cycle_count(cc0), .exit_cause(cause[0]));

  riscv_kernel_ctrl #(.MAX_CYCLES(16)) u_to (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start[1]), .ap_done(done[1]),
    .ap_ready(ready[1]), .ap_idle(idle[1]), .prog_len(prog_len), .core_pc(pc[1]),
    .core_halt(halt[1]), .core_rst(crst[1]), .cycle_count(cc1), .exit_cause(cause[1]));

  riscv_kernel_ctrl #(.CNT_W(4), .DRAIN_CYCLES(0)) u_sat (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start[2]), .ap_done(done[2]),
    .ap_ready(ready[2]), .ap_idle(idle[2]), .prog_len(prog_len), .core_pc(pc[2]),
    .core_halt(halt[2]), .core_rst(crst[2]), .cycle_count(cc2), .exit_cause(cause[2]));

  function automatic int ccv(int i);
    case (i)
      0:       return int'(cc0);
      1:       return int'(cc1);
      default: return int'(cc2);
    endcase
  endfunction

  task automatic chk(string nm, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Core model: PC advances `step` bytes per RUN cycle starting at 0; halt fires
  // on a chosen RUN cycle. rc counts cycles since core_rst dropped.
  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; pc[i] = '0; halt[i] = 1'b0;
    end
  end

  always @(negedge ap_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (crst[i]) rc[i] = 0;
      else         rc[i] = rc[i] + 1;
      pc[i]   = (rc[i] > 0) ? 32'((rc[i] - 1) * step[i]) : 32'd0;
      halt[i] = (halt_at[i] != 0) && (rc[i] == halt_at[i]);
    end
    if (!crst[0]) low0 = low0 + 1;
  end

  // Monitor: every ap_done pops one expected job result for that instance.
  always @(negedge ap_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] || ready[i]) chk($sformatf("ready_eq_done[%0d]", i), int'(ready[i]), int'(done[i]));
      if (done[i]) begin
        exp_t e;
        int   sz;
        case (i)
          0:       sz = q0.size();
          1:       sz = q1.size();
          default: sz = q2.size();
        endcase
        if (sz == 0) begin
          chk($sformatf("unexpected_done[%0d]", i), 1, 0);
        end else begin
          case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          chk($sformatf("cycle_count[%0d]", i), ccv(i), e.cc);
          chk($sformatf("exit_cause[%0d]", i), int'(cause[i]), e.cause);
          chk($sformatf("done_cycle[%0d]", i), cyc, e.done_cyc);
          chk($sformatf("core_rst_in_done[%0d]", i), int'(crst[i]), 1);
        end
      end
    end
  end

  task automatic push(int i, int ccx, int causex, int done_at);
    exp_t e;
    e.cc = ccx; e.cause = causex; e.done_cyc = done_at;
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called at a negedge: start is sampled on the next posedge, and ap_done
  // is then expected `lat` cycles after the current cycle.
  task automatic start_job(int i, int ccx, int causex, int lat);
    push(i, ccx, causex, cyc + lat);
    start[i] = 1'b1;
    @(negedge ap_clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < budget) begin
      @(negedge ap_clk);
      n++;
    end
    chk("jobs_completed_in_budget", q0.size() + q1.size() + q2.size(), 0);
    q0.delete(); q1.delete(); q2.delete();
    repeat (2) @(negedge ap_clk);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge ap_clk);
    // Reset values
    chk("rst_core_rst", int'(crst[0]), 1);
    chk("rst_ap_idle", int'(idle[0]), 1);
    chk("rst_ap_done", int'(done[0]), 0);
    chk("rst_ap_ready", int'(ready[0]), 0);
    chk("rst_cycle_count", ccv(0), 0);
    chk("rst_exit_cause", int'(cause[0]), 0);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    // T1: default end index 40, PC +4/cycle -> end seen at RUN cycle 41.
    // Latency 2 + 41 + 4 + 1; core_rst low for 41 RUN + 4 DRAIN cycles.
    step[0] = 4; halt_at[0] = 0; prog_len = 7'd0;
    start_job(0, 41, 1, 48);
    wait_idle(200);
    chk("t1_core_rst_low_cycles", low0, 45);
    chk("t1_idle_after", int'(idle[0]), 1);

    // T2: end index 10, PC +12/cycle -> idx 12 at RUN cycle 5, halt also at 5.
    // prog_len change during HOLD must be ignored.
    step[0] = 12; halt_at[0] = 5; prog_len = 7'd10;
    start_job(0, 5, 2, 12);
    prog_len = 7'd63;
    wait_idle(100);
    halt_at[0] = 0;

    // T3: 16-cycle timeout with PC stuck at 0.
    prog_len = 7'd0; step[1] = 0;
    start_job(1, 16, 3, 23);
    wait_idle(100);

    // T6: 4-bit counter saturates at 15; halt at RUN cycle 20; no DRAIN.
    step[2] = 0; halt_at[2] = 20;
    start_job(2, 15, 2, 23);
    repeat (19) @(negedge ap_clk);  // RUN cycle 18
    chk("t6_saturated_mid_run", ccv(2), 15);
    chk("t6_core_running", int'(crst[2]), 0);
    wait_idle(100);
    halt_at[2] = 0;

    // T4: ap_start held; end index 3 -> end at RUN cycle 4, latency 11 each.
    prog_len = 7'd3; step[0] = 4;
    push(0, 4, 1, cyc + 11);
    push(0, 4, 1, cyc + 22);
    start[0] = 1'b1;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!done[0] && n < 50);
    chk("t4_first_done_seen", int'(done[0]), 1);
    chk("t4_idle_in_done", int'(idle[0]), 0);
    @(negedge ap_clk);
    chk("t4_rehold_idle", int'(idle[0]), 0);
    chk("t4_rehold_core_rst", int'(crst[0]), 1);
    chk("t4_rehold_cycle_count", ccv(0), 0);
    chk("t4_rehold_exit_cause", int'(cause[0]), 0);
    start[0] = 1'b0;
    wait_idle(100);

    // T5: asynchronous reset mid-RUN; no ap_done may follow.
    prog_len = 7'd0; step[0] = 4;
    start[0] = 1'b1;
    @(negedge ap_clk);
    start[0] = 1'b0;
    repeat (10) @(negedge ap_clk);
    chk("t5_running_before_rst", int'(crst[0]), 0);
    #3 ap_rst_n = 1'b0;
    #1;
    chk("t5_async_core_rst", int'(crst[0]), 1);
    chk("t5_async_ap_idle", int'(idle[0]), 1);
    chk("t5_async_cycle_count", ccv(0), 0);
    chk("t5_async_ap_done", int'(done[0]), 0);
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    repeat (60) @(negedge ap_clk);
    chk("t5_stays_idle", int'(idle[0]), 1);
    chk("t5_exit_cause_cleared", int'(cause[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
